// File: rtl/ixu_pkg.sv
// ixu_pkg -- shared definitions for the IXU issue controller.
// Holds the accepted opcode constants, the NOP encoding, the controller state
// enum and helpers that pull RV32 fields out of an instruction word.
package ixu_pkg;

  localparam logic [6:0]  OPC_R = 7'b0110011;
  localparam logic [6:0]  OPC_I = 7'b0010011;
  localparam logic [31:0] NOP   = 32'h0;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HAZARD = 2'd1,
    ST_ISSUE  = 2'd2
  } state_t;

  function automatic logic [6:0] f_opc(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic [4:0] f_rs1(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] inst);
    return inst[24:20];
  endfunction

  function automatic logic is_legal(input logic [31:0] inst);
    return (f_opc(inst) == OPC_R) || (f_opc(inst) == OPC_I);
  endfunction

  // x0 is excluded explicitly so a stray bit 0 can never stall anything.
  function automatic logic has_hazard(input logic [31:0] inst, input logic [31:0] busy);
    logic h;
    h = 1'b0;
    if (f_rs1(inst) != 5'd0 && busy[f_rs1(inst)]) h = 1'b1;
    if (f_opc(inst) == OPC_R && f_rs2(inst) != 5'd0 && busy[f_rs2(inst)]) h = 1'b1;
    if (f_rd(inst) != 5'd0 && busy[f_rd(inst)]) h = 1'b1;
    return h;
  endfunction

endpackage

// File: rtl/ixu_scoreboard.sv
// ixu_scoreboard -- registered busy bit per architectural register.
// Ports: clk, rst_n; set_en/set_idx mark a register pending (issue);
// clr_en/clr_idx release it (writeback); busy_vec is the registered result.
// A set and clear of the same index in one cycle leaves the bit set.
module ixu_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  output logic [31:0] busy_vec
);

  logic [31:0] busy_q;
  logic [31:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 32'h0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/ixu_issue_ctrl.sv
// ixu_issue_ctrl -- single-slot issue buffer with a register scoreboard.
// Ports: clk, rst_n; in_valid/in_ready/in_inst upstream handshake;
// iss_valid/iss_ready/iss_inst towards the IXU; wb_valid/wb_rd writeback;
// flush discards the held instruction; busy_vec scoreboard; stall_cnt
// saturating HAZARD cycle count; err_illegal one-cycle drop pulse.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_EMPTY  | nothing held, ready for a new instruction
// ST_HAZARD | instruction held, an operand or dest is busy
// ST_ISSUE  | instruction held and presented (iss_valid=1)
module ixu_issue_ctrl
  import ixu_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [31:0]            iss_inst,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   flush,
  output logic [31:0]            busy_vec,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   err_illegal
);

  state_t                 state_q, state_d;
  logic [31:0]            held_q;
  logic                   err_q;
  logic [STALL_CNT_W-1:0] stall_q;

  logic        accept, new_ok, bad_drop, issue_fire, set_en;
  logic [31:0] busy_la;

  assign accept     = in_valid && in_ready;
  assign new_ok     = accept && (in_inst != NOP) && is_legal(in_inst);
  assign bad_drop   = accept && (in_inst != NOP) && !is_legal(in_inst);
  assign issue_fire = iss_valid && iss_ready && !flush;
  assign set_en     = issue_fire && (f_rd(held_q) != 5'd0);
  // A newly accepted instruction must also see the dest being set this cycle.
  assign busy_la    = busy_vec | (set_en ? (32'd1 << f_rd(held_q)) : 32'd0);

  ixu_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_idx  (f_rd(held_q)),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .busy_vec (busy_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      held_q  <= 32'h0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if (new_ok) held_q <= in_inst;
      err_q <= bad_drop;
      if (state_q == ST_HAZARD && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  // Held-instruction hazards use busy_vec only, so a writeback releases the
  // stall one cycle after it lands in the scoreboard.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (new_ok) begin
      state_d = has_hazard(in_inst, busy_la) ? ST_HAZARD : ST_ISSUE;
    end else begin
      case (state_q)
        ST_EMPTY:  state_d = ST_EMPTY;
        ST_HAZARD: state_d = has_hazard(held_q, busy_vec) ? ST_HAZARD : ST_ISSUE;
        ST_ISSUE:  state_d = issue_fire ? ST_EMPTY : ST_ISSUE;
        default:   state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    iss_valid = (state_q == ST_ISSUE);
    in_ready  = rst_n && !flush && ((state_q == ST_EMPTY) || (iss_valid && iss_ready));
  end

  assign iss_inst    = held_q;
  assign stall_cnt   = stall_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_ixu_issue_ctrl.sv
module tb_ixu_issue_ctrl;

  localparam int SW = 4;
  localparam logic [31:0] I_ADD  = 32'h003100B3; // add  x1,x2,x3
  localparam logic [31:0] I_ADDI = 32'h00128213; // addi x4,x5,1
  localparam logic [31:0] I_SUB  = 32'h40708333; // sub  x6,x1,x7
  localparam logic [31:0] I_A9   = 32'h00500493; // addi x9,x0,5
  localparam logic [31:0] I_A0   = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] I_A11  = 32'h00100593; // addi x11,x0,1
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, iss_valid, iss_ready, wb_valid, flush, err_illegal;
  logic [31:0]   in_inst, iss_inst, busy_vec;
  logic [4:0]    wb_rd;
  logic [SW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ixu_issue_ctrl #(.STALL_CNT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_inst(iss_inst), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt), .err_illegal(err_illegal)
  );

  typedef struct {
    logic        iv;
    logic [31:0] inst;
    logic        ir;
    logic        wv;
    logic [4:0]  wrd;
    logic        fl;
    logic        e_rdy;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_busy;
    logic        e_err;
    int          e_stall;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] inst, input logic ir,
                       input logic wv, input logic [4:0] wrd, input logic fl);
    @(negedge clk);
    in_valid = iv; in_inst = inst; iss_ready = ir; wb_valid = wv; wb_rd = wrd; flush = fl;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_iss_valid"}, {31'b0, iss_valid}, 32'd0);
    chk({tag, "_iss_inst"}, iss_inst, 32'h0);
    chk({tag, "_busy"}, busy_vec, 32'h0);
    chk({tag, "_stall"}, 32'(stall_cnt), 32'd0);
    chk({tag, "_err"}, {31'b0, err_illegal}, 32'd0);
  endtask

  initial begin
    // iv inst ir wv wrd fl | rdy iv inst busy err stall
    vt[0]  = '{1'b1, I_ADD,  1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h000, 1'b0, 0};
    vt[1]  = '{1'b1, I_ADDI, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, I_ADD,  32'h000, 1'b0, 0};
    vt[2]  = '{1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, I_ADDI, 32'h002, 1'b0, 0};
    vt[3]  = '{1'b1, I_SUB,  1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h012, 1'b0, 0};
    vt[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h012, 1'b0, 0};
    vt[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h012, 1'b0, 1};
    vt[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h010, 1'b0, 2};
    vt[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, I_SUB,  32'h010, 1'b0, 3};
    vt[8]  = '{1'b1, 32'h0,  1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h050, 1'b0, 3};
    vt[9]  = '{1'b1, I_BAD,  1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h050, 1'b0, 3};
    vt[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 32'h0,  32'h050, 1'b1, 3};
    vt[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 32'h0,  32'h040, 1'b0, 3};
    vt[12] = '{1'b1, I_A9,   1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h040, 1'b0, 3};
    vt[13] = '{1'b0, 32'h0,  1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, I_A9,   32'h040, 1'b0, 3};
    vt[14] = '{1'b1, I_A0,   1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h240, 1'b0, 3};
    vt[15] = '{1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, I_A0,   32'h240, 1'b0, 3};
    vt[16] = '{1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h240, 1'b0, 3};

    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h0; iss_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #2 chk_reset_vals("rst0");
    @(negedge clk); rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].iv, vt[i].inst, vt[i].ir, vt[i].wv, vt[i].wrd, vt[i].fl);
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vt[i].e_rdy});
      chk($sformatf("v%0d_iss_valid", i), {31'b0, iss_valid}, {31'b0, vt[i].e_iv});
      if (vt[i].e_iv) chk($sformatf("v%0d_iss_inst", i), iss_inst, vt[i].e_inst);
      chk($sformatf("v%0d_busy", i), busy_vec, vt[i].e_busy);
      chk($sformatf("v%0d_err", i), {31'b0, err_illegal}, {31'b0, vt[i].e_err});
      chk($sformatf("v%0d_stall", i), 32'(stall_cnt), 32'(vt[i].e_stall));
    end

    // backpressure: held addi x4 must stay put for 5 cycles
    drive(1'b1, I_ADDI, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("bp_accept_rdy", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, I_ADD, 1'b0, 1'b0, 5'd0, 1'b0);
      chk($sformatf("bp%0d_iss_valid", k), {31'b0, iss_valid}, 32'd1);
      chk($sformatf("bp%0d_iss_inst", k), iss_inst, I_ADDI);
      chk($sformatf("bp%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("bp_release_valid", {31'b0, iss_valid}, 32'd1);
    chk("bp_release_rdy", {31'b0, in_ready}, 32'd1);
    idle();
    chk("bp_after_valid", {31'b0, iss_valid}, 32'd0);
    chk("bp_after_busy", busy_vec, 32'h250);

    // flush while in HAZARD (sub x6 waits on busy x6)
    drive(1'b1, I_SUB, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("fh_accept_rdy", {31'b0, in_ready}, 32'd1);
    idle();
    chk("fh_haz_valid", {31'b0, iss_valid}, 32'd0);
    chk("fh_haz_rdy", {31'b0, in_ready}, 32'd0);
    chk("fh_haz_stall", 32'(stall_cnt), 32'd3);
    drive(1'b1, I_ADDI, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("fh_flush_rdy", {31'b0, in_ready}, 32'd0);
    idle();
    chk("fh_post_rdy", {31'b0, in_ready}, 32'd1);
    chk("fh_post_valid", {31'b0, iss_valid}, 32'd0);
    chk("fh_post_busy", busy_vec, 32'h250);
    chk("fh_post_stall", 32'(stall_cnt), 32'd5);

    // flush overrides an issue handshake: x11 must not become busy
    drive(1'b1, I_A11, 1'b0, 1'b0, 5'd0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1);
    chk("fi_flush_valid", {31'b0, iss_valid}, 32'd1);
    chk("fi_flush_rdy", {31'b0, in_ready}, 32'd0);
    idle();
    chk("fi_post_valid", {31'b0, iss_valid}, 32'd0);
    chk("fi_post_busy", busy_vec, 32'h250);

    // stall counter saturation (width 4 -> 15)
    drive(1'b1, I_SUB, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (16) idle();
    chk("sat_stall", 32'(stall_cnt), 32'd15);
    chk("sat_valid", {31'b0, iss_valid}, 32'd0);
    idle();
    chk("sat_hold", 32'(stall_cnt), 32'd15);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    idle();

    // reset mid-operation with held inst and busy_vec=0x2
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, I_ADD, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("rs_first_rdy", {31'b0, in_ready}, 32'd1);
    drive(1'b1, I_SUB, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("rs_issue_valid", {31'b0, iss_valid}, 32'd1);
    idle();
    chk("rs_held_busy", busy_vec, 32'h2);
    chk("rs_held_haz", {31'b0, iss_valid}, 32'd0);
    rst_n = 1'b0;
    #1 chk_reset_vals("rst1");
    @(negedge clk); #2 chk_reset_vals("rst2");
    rst_n = 1'b1;
    #1 chk("rs_rel_rdy", {31'b0, in_ready}, 32'd1);
    idle();
    chk("rs_rel_valid", {31'b0, iss_valid}, 32'd0);
    chk("rs_rel_busy", busy_vec, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ixu_issue_ctrl.md
IXU_ISSUE_CTRL -- requirements
Module: ixu_issue_ctrl

Interface
REQ-001 Parameter: STALL_CNT_W, default 16, width of saturating stall counter.
REQ-002 clk  input  1  block clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream slot holds an instruction.
REQ-005 in_ready  output  1  block accepts in_inst this cycle.
REQ-006 in_inst  input  32  RV32 R/I-type ALU instruction, or 32'h0 NOP.
REQ-007 iss_valid  output  1  held instruction is presented to the IXU.
REQ-008 iss_ready  input  1  IXU accepts iss_inst this cycle.
REQ-009 iss_inst  output  32  instruction to IXU; valid only with iss_valid.
REQ-010 wb_valid / wb_rd  input  1 / 5  IXU writeback completes to register wb_rd.
REQ-011 flush  input  1  discard held instruction.
REQ-012 busy_vec  output  32  registered scoreboard, bit i = x_i has a pending write.
REQ-013 stall_cnt  output  STALL_CNT_W  cycles spent in HAZARD, saturating.
REQ-014 err_illegal  output  1  one-cycle pulse on illegal opcode drop.

Function
REQ-015 States: EMPTY (no held inst), HAZARD (held, operand/dest busy), ISSUE (held, iss_valid=1).
REQ-016 in_ready = (state==EMPTY) or (iss_valid and iss_ready); throughput one instruction per cycle, no hazards.
REQ-017 Accept (in_valid and in_ready) at cycle N latches in_inst; iss_valid earliest at N+1.
REQ-018 Accepted 32'h0 is dropped: no hold, no busy set, state EMPTY.
REQ-019 Accepted inst with opcode not 7'b0110011 or 7'b0010011 is dropped; err_illegal=1 at N+1.
REQ-020 Hazard = busy[rs1] or (R-type and busy[rs2]) or busy[rd]; evaluated from registered busy_vec each cycle.
REQ-021 x0 never busy; index 0 never set; rs=0/rd=0 never cause hazard.
REQ-022 No same-cycle bypass: wb clear visible in busy_vec next cycle; hazard may release one cycle after wb_valid.
REQ-023 Held inst with hazard: state HAZARD, iss_valid=0; else ISSUE, iss_valid=1.
REQ-024 iss_valid, once high, stays high with iss_inst stable until iss_ready or flush.
REQ-025 On issue handshake with rd!=0, busy[rd] set next cycle.
REQ-026 Same cycle issue sets and wb clears same rd: set wins.
REQ-027 wb_valid with wb_rd=0 or non-busy reg: no effect.
REQ-028 Issue handshake with simultaneous new accept: next state ISSUE/HAZARD per new inst; else EMPTY.
REQ-029 flush: held inst discarded, state EMPTY next cycle, in_ready=0 during flush cycle; busy_vec unchanged; flush overrides accept and issue.
REQ-030 stall_cnt increments each cycle in HAZARD; holds at 2^STALL_CNT_W-1.

Reset
REQ-031 rst_n low: state EMPTY, iss_valid=0, iss_inst=0, busy_vec=0, stall_cnt=0, err_illegal=0, in_ready=0.
REQ-032 First cycle after rst_n deasserts: in_ready=1.
REQ-033 Reset mid-operation drops held instruction and all busy bits; no issue completes in reset.

Structure
REQ-034 Shared package ixu_pkg holds opcode constants OPC_R=7'b0110011, OPC_I=7'b0010011, NOP=32'h0, and state enum.
REQ-035 Scoreboard is sub-module ixu_scoreboard: set port, clear port, set-wins, busy_vec out.
REQ-036 Field extraction (rd, rs1, rs2, opcode) uses fixed RV32 bit positions.

Verification
REQ-037 Back-to-back independent: add x1,x2,x3 then addi x4,x5,1, iss_ready=1 -> issued on consecutive cycles, busy_vec=0x12.
REQ-038 RAW: add x1,x2,x3 issued, then sub x6,x1,x7 -> HAZARD until wb_rd=1; issues 2 cycles after wb_valid; stall_cnt counts those cycles.
REQ-039 Backpressure: iss_ready=0 for 5 cycles -> iss_valid=1, iss_inst stable, in_ready=0 throughout.
REQ-040 NOP and illegal: in_inst=0 -> nothing issued; in_inst=0x0000007F -> dropped, err_illegal 1-cycle pulse.
REQ-041 Flush in HAZARD -> EMPTY next cycle, iss_valid stays 0, busy_vec unchanged.
REQ-042 Reset with held inst and busy_vec=0x2 -> all outputs at reset values, busy_vec=0.
